// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data_mem arbiter; also imported by its testbench.
package data_mem_arb_pkg;
  import riscv_32i_defs_pkg::*;

  localparam int NUM_REQ_DFLT      = 2;
  localparam int LOCK_TIMEOUT_DFLT = 16;

  typedef logic [$clog2(NUM_REQ_DFLT)-1:0] req_idx_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;
endpackage

// File: rtl/riscv_32i_defs_pkg.sv
// Base RV32I word and address types shared across the core and its memory subsystem.
package riscv_32i_defs_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] word_t;
  typedef logic [XLEN-1:0] addr_t;
endpackage

// File: rtl/data_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter with an optional single-owner lock override.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  input  logic          lock_en,
  input  logic [IW-1:0] lock_owner,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  logic [IW-1:0] cand_idx;

  // First requester at or after rr_ptr wins; a held lock restricts eligibility to its owner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand_idx  = '0;
    if (lock_en) begin
      if (req[lock_owner]) begin
        grant[lock_owner] = 1'b1;
        grant_idx         = lock_owner;
        grant_vld         = 1'b1;
      end else begin
        grant_vld = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        cand_idx = IW'((int'(rr_ptr) + k) % N);
        if (!grant_vld && req[cand_idx]) begin
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
          grant_vld       = 1'b1;
        end else begin
          grant_vld = grant_vld;
        end
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares single-port data_mem among NUM_REQ valid/ready requesters with round-robin
// grant, an RMW lock with idle timeout, and a registered one-cycle-latency response.
module data_mem_arbiter
  import riscv_32i_defs_pkg::*;
  import data_mem_arb_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DFLT,
  parameter int ADDR_WIDTH   = $bits(addr_t),
  parameter int DATA_WIDTH   = $bits(word_t),
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DFLT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_wr_sel,
  input  logic [NUM_REQ-1:0]                  req_lock,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wr_data,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_rd_data,
  output logic                                mem_wr_sel,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [DATA_WIDTH-1:0]               mem_wr_data,
  input  logic [DATA_WIDTH-1:0]               mem_rd_data,
  output logic                                lock_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  lock_state_e         state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       lock_owner_q, lock_owner_d;
  logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rd_data_q, rsp_rd_data_d;
  logic                lock_err_q, lock_err_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IW-1:0]       grant_idx;
  logic                grant_vld;
  logic                hs;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return i + IW'(1);
    end
  endfunction

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr_arbiter (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .lock_en    (state_q == ST_LOCKED),
    .lock_owner (lock_owner_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // A grant is only a handshake outside reset, so nothing reaches memory while rst is high.
  assign hs = grant_vld & ~rst;

  // Memory mux and ready are combinational so data_mem writes on the handshake edge itself.
  always_comb begin
    req_ready   = '0;
    mem_wr_sel  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (hs) begin
      req_ready   = grant;
      mem_wr_sel  = req_wr_sel[grant_idx];
      mem_addr    = req_addr[grant_idx];
      mem_wr_data = req_wr_data[grant_idx];
    end else begin
      req_ready = '0;
    end
  end

  // Next-state for the lock FSM, round-robin pointer, timeout counter and response.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    lock_owner_d  = lock_owner_q;
    lock_cnt_d    = lock_cnt_q;
    lock_err_d    = 1'b0;
    rsp_valid_d   = hs ? grant : '0;
    rsp_rd_data_d = (hs && !req_wr_sel[grant_idx]) ? mem_rd_data : '0;
    case (state_q)
      ST_UNLOCKED: begin
        if (hs && req_lock[grant_idx]) begin
          state_d      = ST_LOCKED;
          lock_owner_d = grant_idx;
          lock_cnt_d   = '0;
        end else if (hs) begin
          rr_ptr_d = next_idx(grant_idx);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ST_LOCKED: begin
        if (hs) begin
          lock_cnt_d = '0;
          if (!req_lock[grant_idx]) begin
            state_d  = ST_UNLOCKED;
            rr_ptr_d = next_idx(lock_owner_q);
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (lock_cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          state_d    = ST_UNLOCKED;
          rr_ptr_d   = next_idx(lock_owner_q);
          lock_cnt_d = '0;
          lock_err_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase
  end

  // State registers; reset also drops any response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_UNLOCKED;
      rr_ptr_q      <= '0;
      lock_owner_q  <= '0;
      lock_cnt_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_rd_data_q <= '0;
      lock_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_owner_q  <= lock_owner_d;
      lock_cnt_q    <= lock_cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_data_q <= rsp_rd_data_d;
      lock_err_q    <= lock_err_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd_data = rsp_rd_data_q;
  assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: stimulus pushes expected responses, a monitor checks them.
module tb_data_mem_arbiter;
  import riscv_32i_defs_pkg::*;
  import data_mem_arb_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0]       req_ready;
  logic [1:0]       req_wr_sel = 2'b00;
  logic [1:0]       req_lock = 2'b00;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0][31:0] req_wr_data = '0;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rd_data;
  logic             mem_wr_sel;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wr_data;
  logic [31:0]      mem_rd_data;
  logic             lock_err;

  logic [31:0] mem [0:63];

  typedef struct packed {
    logic [1:0]  v;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(
    .NUM_REQ(NUM_REQ_DFLT), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LOCK_TIMEOUT(LOCK_TIMEOUT_DFLT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr_sel(req_wr_sel), .req_lock(req_lock),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .mem_wr_sel(mem_wr_sel), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .lock_err(lock_err)
  );

  // Behavioural data_mem: combinational read, write on the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_wr_sel) begin
      mem[mem_addr[7:2]] <= mem_wr_data;
    end
  end
  assign mem_rd_data = mem[mem_addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: drive after the edge, check grant and lock_err, queue the response.
  task automatic step(input string nm, input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                      input logic [31:0] a0, input logic [31:0] d0,
                      input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] er, input logic [31:0] ed, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v; req_wr_sel = w; req_lock = l;
    req_addr[0] = a0; req_wr_data[0] = d0;
    req_addr[1] = a1; req_wr_data[1] = d1;
    #1;
    chk({nm, " ready"}, {30'h0, req_ready}, {30'h0, er});
    chk({nm, " lock_err"}, {31'h0, lock_err}, {31'h0, ee});
    if (er != 2'b00) begin
      e.v = er;
      e.d = ed;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: every response pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected rsp_valid", {30'h0, rsp_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_valid", {30'h0, rsp_valid}, {30'h0, e.v});
          chk("rsp_rd_data", rsp_rd_data, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 2'b11; req_wr_sel = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ready", {30'h0, req_ready}, 32'h0);
    chk("reset mem_wr_sel", {31'h0, mem_wr_sel}, 32'h0);
    chk("reset rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("reset lock_err", {31'h0, lock_err}, 32'h0);
    req_valid = 2'b00; req_wr_sel = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post-reset rsp_valid", {30'h0, rsp_valid}, 32'h0);

    //      name         v      w      l      a0     d0            a1     d1    er     ed            ee
    step("first grant", 2'b11, 2'b00, 2'b00, 32'h0, 32'h0,        32'h0, 32'h0, 2'b01, 32'h0,        1'b0);
    step("wr0 10",      2'b01, 2'b01, 2'b00, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, 2'b01, 32'h0,       1'b0);
    step("rd0 10",      2'b01, 2'b00, 2'b00, 32'h10, 32'h0,       32'h0, 32'h0, 2'b01, 32'hDEADBEEF, 1'b0);
    step("rd1 10",      2'b10, 2'b00, 2'b00, 32'h0, 32'h0,        32'h10, 32'h0, 2'b10, 32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("contention", 2'b11, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0,
           (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 32'hDEADBEEF : 32'h0, 1'b0);
    end
    step("hazard wr0",  2'b01, 2'b01, 2'b00, 32'h20, 32'h12345678, 32'h0, 32'h0, 2'b01, 32'h0,       1'b0);
    step("hazard rd1",  2'b10, 2'b00, 2'b00, 32'h0, 32'h0,        32'h20, 32'h0, 2'b10, 32'h12345678, 1'b0);
    step("lock rd0",    2'b11, 2'b00, 2'b01, 32'h20, 32'h0,       32'h24, 32'h0, 2'b01, 32'h12345678, 1'b0);
    step("locked idle", 2'b10, 2'b00, 2'b00, 32'h20, 32'h0,       32'h24, 32'h0, 2'b00, 32'h0,        1'b0);
    step("unlock wr0",  2'b11, 2'b01, 2'b00, 32'h24, 32'hCAFEF00D, 32'h24, 32'h0, 2'b01, 32'h0,       1'b0);
    step("after unlock",2'b11, 2'b00, 2'b00, 32'h24, 32'h0,       32'h24, 32'h0, 2'b10, 32'hCAFEF00D, 1'b0);
    step("lock rd0 b",  2'b11, 2'b00, 2'b01, 32'h24, 32'h0,       32'h20, 32'h0, 2'b01, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step("timeout wait", 2'b10, 2'b00, 2'b00, 32'h0, 32'h0, 32'h20, 32'h0, 2'b00, 32'h0, 1'b0);
    end
    step("timeout",     2'b10, 2'b00, 2'b00, 32'h0, 32'h0,        32'h20, 32'h0, 2'b10, 32'h12345678, 1'b1);
    step("idle",        2'b00, 2'b00, 2'b00, 32'h0, 32'h0,        32'h0, 32'h0,  2'b00, 32'h0,        1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
